execute_cc_stage: RTL
=====================

Name: execute_cc_stage

Overview:
- Execute-stage back end of the Y86-64 pipeline; sits directly downstream of the 64-bit ALU, including the subtract path.
- Captures ALU result and overflow, and maintains the condition-code register (ZF/SF/OF).
- Evaluates the branch/cmov condition against the current CC, squashes the cmov destination when the condition fails, and registers everything into the E->M pipeline register with stall/bubble control.

Parameters:
WIDTH, 64, datapath width of valE/valA
RNONE, 4'hF, register ID meaning "no destination"

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
e_valid  input  1  execute stage holds a real instruction
e_icode  input  4  instruction code (2=cmovXX/rrmovq, 6=OPq, 7=jXX, 1=nop)
e_ifun  input  4  function code / condition selector
e_alu_result  input  WIDTH  ALU output (sum/difference/logic)
e_alu_overflow  input  1  ALU signed-overflow flag
e_valA  input  WIDTH  operand A passthrough
e_dstE  input  4  destination register for valE
e_dstM  input  4  destination register for memory read
cc_inhibit  input  1  suppress CC write (exception in M or W)
m_stall  input  1  hold M register contents
m_bubble  input  1  load nop into M register
zf, sf, of  output  1 each  current CC register
e_cnd  output  1  combinational condition result for the current instruction
m_valid  output  1  registered valid
m_icode  output  4  registered icode
m_cnd  output  1  registered condition
m_valE  output  WIDTH  registered ALU result
m_valA  output  WIDTH  registered valA
m_dstE  output  4  registered (possibly squashed) dstE
m_dstM  output  4  registered dstM

Behaviour:
- Reset (async, immediate on rst=1):
  - zf=1, sf=0, of=0.
  - m_valid=0, m_icode=1 (nop), m_cnd=0, m_valE=0, m_valA=0, m_dstE=RNONE, m_dstM=RNONE.
- Condition evaluation (combinational, from CC register values before this cycle's update):
  - e_ifun 0 -> always 1; 1 -> le = (sf^of)|zf; 2 -> l = sf^of; 3 -> e = zf; 4 -> ne = ~zf; 5 -> ge = ~(sf^of); 6 -> g = ~(sf^of)&~zf; ifun>6 -> 0.
  - e_cnd equals the selected value only when e_icode is 2 or 7; otherwise e_cnd=0.
- dstE squash: if e_icode==2 and e_cnd==0, the registered dstE is RNONE; otherwise it is e_dstE.
- CC update:
  - set_cc = e_valid & (e_icode==6) & ~cc_inhibit & ~m_stall.
  - When set_cc=1, on the rising edge: zf <= (e_alu_result==0), sf <= e_alu_result[WIDTH-1], of <= e_alu_overflow.
  - CC is otherwise held.
  - The CC update is independent of m_bubble.
- M register (rising edge, priority rst > m_stall > m_bubble > load):
  - m_stall=1: all m_* hold.
  - m_bubble=1 (and not stalled): load reset values (nop), except CC, which follows set_cc.
  - Otherwise: load m_valid<=e_valid and the other m_* from the e_* inputs; m_valE<=e_alu_result.
  - e_valid=0 loads the fields as-is with m_valid=0; downstream ignores them.
- Latency: one cycle from e_* inputs to m_* outputs; CC visible to e_cnd on the cycle after the OPq.
- Back-to-back OPq then jXX: the jXX sees the CC written by the OPq (written at the edge between them). No CC bypass within the same cycle.
- rst asserted mid-operation clears CC and M register immediately, regardless of stall/bubble.
- WIDTH applies to valE/valA only; the CC zero check spans the full WIDTH bits.

Test Plan:
- Reset: assert rst async between edges -> outputs immediately at reset values; zf=1, sf=0, of=0, m_icode=1, m_dstE=F.
- OPq subq result 0 (e_icode=6, e_alu_result=0, overflow=0), next cycle jXX je (icode 7, ifun 3) -> zf=1, sf=0, of=0 after edge; e_cnd=1 on jXX; m_cnd=1 one cycle later.
- OPq result 64'h8000000000000000 with overflow=1, then cmovl (icode 2, ifun 2, dstE=3) -> sf=1, of=1, sf^of=0 so e_cnd=0, m_dstE=F; repeat with overflow=0 -> e_cnd=1, m_dstE=3.
- OPq with cc_inhibit=1, result 5 -> CC unchanged (zf=1 from reset); m_valE=5 still registered.
- m_stall=1 for 2 cycles while OPq result 7 presented -> m_* hold previous values, CC not updated; release -> m_valE=7, zf=0.
- m_stall and m_bubble both 1 -> hold; m_bubble alone -> m_icode=1, m_valid=0, m_dstE=F, m_dstM=F; concurrent OPq result 0 still sets zf=1.

Source files
------------

// File: rtl/execute_cc_stage_if.sv
// Execute-to-memory bundle for the Y86-64 execute back end.
// The pipeline front end drives the e_* and control signals, and the stage returns CC, e_cnd and the M register.
interface execute_cc_stage_if #(parameter int WIDTH = 64);
  logic             e_valid;
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic [WIDTH-1:0] e_alu_result;
  logic             e_alu_overflow;
  logic [WIDTH-1:0] e_valA;
  logic [3:0]       e_dstE;
  logic [3:0]       e_dstM;
  logic             cc_inhibit;
  logic             m_stall;
  logic             m_bubble;
  logic             zf;
  logic             sf;
  logic             of;
  logic             e_cnd;
  logic             m_valid;
  logic [3:0]       m_icode;
  logic             m_cnd;
  logic [WIDTH-1:0] m_valE;
  logic [WIDTH-1:0] m_valA;
  logic [3:0]       m_dstE;
  logic [3:0]       m_dstM;

  modport master (
    output e_valid, e_icode, e_ifun, e_alu_result, e_alu_overflow, e_valA,
           e_dstE, e_dstM, cc_inhibit, m_stall, m_bubble,
    input  zf, sf, of, e_cnd, m_valid, m_icode, m_cnd, m_valE, m_valA,
           m_dstE, m_dstM
  );

  modport slave (
    input  e_valid, e_icode, e_ifun, e_alu_result, e_alu_overflow, e_valA,
           e_dstE, e_dstM, cc_inhibit, m_stall, m_bubble,
    output zf, sf, of, e_cnd, m_valid, m_icode, m_cnd, m_valE, m_valA,
           m_dstE, m_dstM
  );
endinterface

// File: rtl/execute_cc_stage.sv
// Y86-64 execute back end: condition codes, branch/cmov condition, dstE squash
// and the E->M pipeline register with stall/bubble control.
module execute_cc_stage #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  execute_cc_stage_if.slave bus
);
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;

  logic             r_zf;
  logic             r_sf;
  logic             r_of;
  logic             r_valid;
  logic [3:0]       r_icode;
  logic             r_cnd;
  logic [WIDTH-1:0] r_valE;
  logic [WIDTH-1:0] r_valA;
  logic [3:0]       r_dstE;
  logic [3:0]       r_dstM;

  logic             w_lt;
  logic             w_cond;
  logic             w_cnd;
  logic             w_setCc;
  logic [3:0]       w_dstE;

  // Condition uses the CC as registered; an OPq in this same cycle is not bypassed.
  always_comb begin
    w_lt   = r_sf ^ r_of;
    w_cond = 1'b0;
    case (bus.e_ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = w_lt | r_zf;
      4'd2:    w_cond = w_lt;
      4'd3:    w_cond = r_zf;
      4'd4:    w_cond = ~r_zf;
      4'd5:    w_cond = ~w_lt;
      4'd6:    w_cond = ~w_lt & ~r_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_cnd   = ((bus.e_icode == I_CMOV) || (bus.e_icode == I_JXX)) ? w_cond : 1'b0;
  assign w_dstE  = ((bus.e_icode == I_CMOV) && !w_cnd) ? RNONE : bus.e_dstE;
  assign w_setCc = bus.e_valid && (bus.e_icode == I_OPQ) && !bus.cc_inhibit && !bus.m_stall;

  // CC write ignores m_bubble: a bubbled OPq still leaves its flags behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_setCc) begin
      r_zf <= (bus.e_alu_result == '0);
      r_sf <= bus.e_alu_result[WIDTH-1];
      r_of <= bus.e_alu_overflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else if (bus.m_stall) begin
      r_valid <= r_valid;
    end else if (bus.m_bubble) begin
      r_valid <= 1'b0;
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else begin
      r_valid <= bus.e_valid;
      r_icode <= bus.e_icode;
      r_cnd   <= w_cnd;
      r_valE  <= bus.e_alu_result;
      r_valA  <= bus.e_valA;
      r_dstE  <= w_dstE;
      r_dstM  <= bus.e_dstM;
    end
  end

  assign bus.zf      = r_zf;
  assign bus.sf      = r_sf;
  assign bus.of      = r_of;
  assign bus.e_cnd   = w_cnd;
  assign bus.m_valid = r_valid;
  assign bus.m_icode = r_icode;
  assign bus.m_cnd   = r_cnd;
  assign bus.m_valE  = r_valE;
  assign bus.m_valA  = r_valA;
  assign bus.m_dstE  = r_dstE;
  assign bus.m_dstM  = r_dstM;
endmodule
